// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 key-search controller:
//   state_t      - sequencer states
//   owner_t      - which phase owns the single S-RAM port
//   CHAR_*       - printable-byte window used to accept a decrypted message
//   MSG_LENGTH_DEF - default number of decrypted bytes checked
// Helpers:
//   is_msg_char  - 1 when a byte is lower-case ASCII or a space
//   phase_owner  - S-RAM owner implied by a sequencer state
// -----------------------------------------------------------------------------
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CLEAR    = 4'd1,
    INIT     = 4'd2,
    KSA      = 4'd3,
    PRGA     = 4'd4,
    CHK_ADDR = 4'd5,
    CHK_W1   = 4'd6,
    CHK_W2   = 4'd7,
    CHK_EVAL = 4'd8,
    NEXT_KEY = 4'd9,
    FOUND    = 4'd10,
    FAIL     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_KSA  = 2'd2,
    OWN_PRGA = 2'd3
  } owner_t;

  localparam logic [7:0] CHAR_LO = 8'h61;
  localparam logic [7:0] CHAR_HI = 8'h7A;
  localparam logic [7:0] CHAR_SP = 8'h20;

  localparam int MSG_LENGTH_DEF = 32;

  function automatic logic is_msg_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SP);
  endfunction

  function automatic owner_t phase_owner(input state_t st);
    owner_t own;
    case (st)
      INIT:    own = OWN_INIT;
      KSA:     own = OWN_KSA;
      PRGA:    own = OWN_PRGA;
      default: own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/rc4_sram_mux.sv
// -----------------------------------------------------------------------------
// rc4_sram_mux
// Combinational 3:1 mux for the shared S-RAM port. The owner select picks one
// of the INIT / KSA / PRGA request sets; OWN_NONE parks the port (no write,
// address and data zero).
// Ports:
//   owner                          - current port owner
//   init_/ksa_/prga_ addr,wrdata,wren - per-phase S-RAM requests
//   s_addr, s_wrdata, s_wren       - muxed S-RAM port
// -----------------------------------------------------------------------------
module rc4_sram_mux
  import rc4_pkg::*;
(
  input  owner_t      owner,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_wrdata,
  input  logic        init_wren,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  ksa_wrdata,
  input  logic        ksa_wren,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  prga_wrdata,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  // Select the owning phase's request; a non-owner can never write.
  always_comb begin
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    case (owner)
      OWN_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      OWN_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      OWN_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      OWN_NONE: begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
      end
      default: begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// -----------------------------------------------------------------------------
// rc4_key_search_ctrl
// Top-level sequencer for the RC4 cracking datapath. For each candidate key it
// runs S-array init, KSA and PRGA in order, owns the shared S-RAM port, then
// scans the decrypted message for printable text.
//
// Build option KEY_SEARCH_EN:
//   defined   - brute-force search from key 0 up to KEY_MAX; key_in ignored.
//   undefined - one pass with key = key_in; a failed check ends in FAIL.
//
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start               - one-cycle search start (ignored while busy)
//   key_in              - fixed key for the single-pass build
//   key                 - current candidate key (to the KSA)
//   sub_clear           - one-cycle clear pulse to all phase blocks
//   init/ksa/prga_start - one-cycle phase start pulses
//   init/ksa/prga_done  - latched phase-complete levels
//   init/ksa/prga_addr, _wrdata, _wren - per-phase S-RAM requests
//   s_addr, s_wrdata, s_wren - muxed S-RAM port
//   dec_addr, dec_rddata - decrypted-RAM read port (2-cycle read latency)
//   busy, found, exhausted - status
// -----------------------------------------------------------------------------
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int                   KEY_WIDTH  = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX    = 24'h3FFFFF,
  parameter int                   MSG_LENGTH = MSG_LENGTH_DEF
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 sub_clear,
  output logic                 init_start,
  output logic                 ksa_start,
  output logic                 prga_start,
  input  logic                 init_done,
  input  logic                 ksa_done,
  input  logic                 prga_done,
  input  logic [7:0]           init_addr,
  input  logic [7:0]           ksa_addr,
  input  logic [7:0]           prga_addr,
  input  logic [7:0]           init_wrdata,
  input  logic [7:0]           ksa_wrdata,
  input  logic [7:0]           prga_wrdata,
  input  logic                 init_wren,
  input  logic                 ksa_wren,
  input  logic                 prga_wren,
  output logic [7:0]           s_addr,
  output logic [7:0]           s_wrdata,
  output logic                 s_wren,
  output logic [7:0]           dec_addr,
  input  logic [7:0]           dec_rddata,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted
);

  localparam logic [7:0]           IDX_LAST = 8'(MSG_LENGTH - 1);
  localparam logic [KEY_WIDTH-1:0] KEY_ONE  = {{(KEY_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  state_t               state_s;
  owner_t               owner_r;
  logic [KEY_WIDTH-1:0] key_r;
  logic [KEY_WIDTH-1:0] start_key_s;
  logic [7:0]           idx_r;
  logic                 load_key_s;
  logic                 inc_key_s;
  logic                 inc_idx_s;
  logic                 clr_idx_s;
  logic                 sub_clear_r;
  logic                 init_start_r;
  logic                 ksa_start_r;
  logic                 prga_start_r;
  logic                 busy_r;
  logic                 found_r;
  logic                 exhausted_r;

`ifdef KEY_SEARCH_EN
  assign start_key_s = {KEY_WIDTH{1'b0}};
`else
  assign start_key_s = key_in;
`endif

  // Next-state and datapath-control decode. While a phase start pulse is
  // still high, a stale done from the previous use of that block is ignored.
  always_comb begin
    state_s    = state_r;
    load_key_s = 1'b0;
    inc_key_s  = 1'b0;
    inc_idx_s  = 1'b0;
    clr_idx_s  = 1'b0;
    case (state_r)
      IDLE, FOUND, FAIL: begin
        if (start) begin
          state_s    = CLEAR;
          load_key_s = 1'b1;
          clr_idx_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      CLEAR: state_s = INIT;
      INIT: begin
        if (init_done && !init_start_r) begin
          state_s = KSA;
        end else begin
          state_s = INIT;
        end
      end
      KSA: begin
        if (ksa_done && !ksa_start_r) begin
          state_s = PRGA;
        end else begin
          state_s = KSA;
        end
      end
      PRGA: begin
        if (prga_done && !prga_start_r) begin
          state_s = CHK_ADDR;
        end else begin
          state_s = PRGA;
        end
      end
      CHK_ADDR: state_s = CHK_W1;
      CHK_W1:   state_s = CHK_W2;
      CHK_W2:   state_s = CHK_EVAL;
      CHK_EVAL: begin
        if (is_msg_char(dec_rddata)) begin
          if (idx_r == IDX_LAST) begin
            state_s = FOUND;
          end else begin
            inc_idx_s = 1'b1;
            state_s   = CHK_ADDR;
          end
        end else begin
`ifdef KEY_SEARCH_EN
          state_s = NEXT_KEY;
`else
          state_s = FAIL;
`endif
        end
      end
      NEXT_KEY: begin
        // Saturate at KEY_MAX rather than wrapping back to key 0.
        if (key_r == KEY_MAX) begin
          state_s = FAIL;
        end else begin
          inc_key_s = 1'b1;
          clr_idx_s = 1'b1;
          state_s   = CLEAR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and S-RAM owner move on the same edge, so the port never idles
  // between phases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      owner_r <= OWN_NONE;
    end else begin
      state_r <= state_s;
      owner_r <= phase_owner(state_s);
    end
  end

  // Registered pulses and status flags, decoded from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_clear_r  <= 1'b0;
      init_start_r <= 1'b0;
      ksa_start_r  <= 1'b0;
      prga_start_r <= 1'b0;
      busy_r       <= 1'b0;
      found_r      <= 1'b0;
      exhausted_r  <= 1'b0;
    end else begin
      sub_clear_r  <= (state_s == CLEAR);
      init_start_r <= (state_s == INIT) && (state_r != INIT);
      ksa_start_r  <= (state_s == KSA)  && (state_r != KSA);
      prga_start_r <= (state_s == PRGA) && (state_r != PRGA);
      busy_r       <= !(state_s inside {IDLE, FOUND, FAIL});
      found_r      <= (state_s == FOUND);
      exhausted_r  <= (state_s == FAIL);
    end
  end

  // Candidate key: loaded on start, advanced only when leaving NEXT_KEY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_r <= {KEY_WIDTH{1'b0}};
    end else if (load_key_s) begin
      key_r <= start_key_s;
    end else if (inc_key_s) begin
      key_r <= key_r + KEY_ONE;
    end
  end

  // Checker byte index; it doubles as the decrypted-RAM read address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r <= 8'h00;
    end else if (clr_idx_s) begin
      idx_r <= 8'h00;
    end else if (inc_idx_s) begin
      idx_r <= idx_r + 8'h01;
    end
  end

  rc4_sram_mux u_sram_mux (
    .owner       (owner_r),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren)
  );

  assign key        = key_r;
  assign dec_addr   = idx_r;
  assign sub_clear  = sub_clear_r;
  assign init_start = init_start_r;
  assign ksa_start  = ksa_start_r;
  assign prga_start = prga_start_r;
  assign busy       = busy_r;
  assign found      = found_r;
  assign exhausted  = exhausted_r;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rc4_key_search_ctrl
// Directed bench for rc4_key_search_ctrl with small behavioural phase models
// (4 write cycles, then a latched done) and a 2-cycle-latency decrypted RAM
// that returns real plaintext only for the "good" key.
// -----------------------------------------------------------------------------
module tb_rc4_key_search_ctrl;

  localparam int             KW   = 24;
  localparam int             ML   = 32;
  localparam logic [KW-1:0]  KMAX = 24'h000003;
`ifdef KEY_SEARCH_EN
  localparam bit SEARCH = 1'b1;
`else
  localparam bit SEARCH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] key_in = '0;
  logic [KW-1:0] key;
  logic          sub_clear, init_start, ksa_start, prga_start;
  logic          init_done = 1'b0, ksa_done = 1'b0, prga_done = 1'b0;
  logic [7:0]    init_addr, ksa_addr, prga_addr;
  logic [7:0]    init_wrdata, ksa_wrdata, prga_wrdata;
  logic          init_wren, ksa_wren, prga_wren;
  logic [7:0]    s_addr, s_wrdata;
  logic          s_wren;
  logic [7:0]    dec_addr;
  logic [7:0]    dec_rddata = 8'h00;
  logic          busy, found, exhausted;

  logic [2:0]    init_cnt = 3'd0, ksa_cnt = 3'd0, prga_cnt = 3'd0;
  logic          inj_wren = 1'b0;
  logic [7:0]    mem [0:ML-1];
  logic [KW-1:0] good_key = '0;
  logic [7:0]    rd_p1 = 8'h00;

  int n_chk = 0;
  int n_pass = 0;

  rc4_key_search_ctrl #(.KEY_WIDTH(KW), .KEY_MAX(KMAX), .MSG_LENGTH(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in), .key(key),
    .sub_clear(sub_clear), .init_start(init_start), .ksa_start(ksa_start),
    .prga_start(prga_start), .init_done(init_done), .ksa_done(ksa_done),
    .prga_done(prga_done), .init_addr(init_addr), .ksa_addr(ksa_addr),
    .prga_addr(prga_addr), .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata),
    .prga_wrdata(prga_wrdata), .init_wren(init_wren), .ksa_wren(ksa_wren),
    .prga_wren(prga_wren), .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .dec_addr(dec_addr), .dec_rddata(dec_rddata), .busy(busy), .found(found),
    .exhausted(exhausted)
  );

  always #5 clk = ~clk;

  // Phase models: start -> 4 write cycles -> done latched; sub_clear clears.
  always @(posedge clk) begin
    if (sub_clear) begin init_done <= 1'b0; init_cnt <= 3'd0; end
    else if (init_start) begin init_done <= 1'b0; init_cnt <= 3'd4; end
    else if (init_cnt != 3'd0) begin
      init_cnt <= init_cnt - 3'd1;
      if (init_cnt == 3'd1) init_done <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (sub_clear) begin ksa_done <= 1'b0; ksa_cnt <= 3'd0; end
    else if (ksa_start) begin ksa_done <= 1'b0; ksa_cnt <= 3'd4; end
    else if (ksa_cnt != 3'd0) begin
      ksa_cnt <= ksa_cnt - 3'd1;
      if (ksa_cnt == 3'd1) ksa_done <= 1'b1;
    end
  end
  always @(posedge clk) begin
    if (sub_clear) begin prga_done <= 1'b0; prga_cnt <= 3'd0; end
    else if (prga_start) begin prga_done <= 1'b0; prga_cnt <= 3'd4; end
    else if (prga_cnt != 3'd0) begin
      prga_cnt <= prga_cnt - 3'd1;
      if (prga_cnt == 3'd1) prga_done <= 1'b1;
    end
  end

  assign init_wren   = (init_cnt != 3'd0);
  assign ksa_wren    = (ksa_cnt != 3'd0) | inj_wren;
  assign prga_wren   = (prga_cnt != 3'd0) | inj_wren;
  assign init_addr   = 8'h10 + {5'd0, init_cnt};
  assign ksa_addr    = 8'h20 + {5'd0, ksa_cnt};
  assign prga_addr   = 8'h30 + {5'd0, prga_cnt};
  assign init_wrdata = 8'hA0 + {5'd0, init_cnt};
  assign ksa_wrdata  = 8'hB0 + {5'd0, ksa_cnt};
  assign prga_wrdata = 8'hC0 + {5'd0, prga_cnt};

  // Decrypted RAM, 2-cycle read latency; wrong keys decrypt to 8'h7B.
  always @(posedge clk) begin
    rd_p1      <= (key == good_key) ? mem[dec_addr[4:0]] : 8'h7B;
    dec_rddata <= rd_p1;
  end

  // Event monitor: cycle stamps of PRGA completion and of the terminal flag.
  int            cyc = 0, prga_rise = 0, term_rise = 0, n_clear = 0, key_moves = 0;
  logic          prga_prev = 1'b0, term_prev = 1'b0;
  logic [KW-1:0] key_prev = '0;
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prga_prev <= prga_done;
    term_prev <= found | exhausted;
    key_prev  <= key;
    if (prga_done && !prga_prev) prga_rise <= cyc;
    if ((found || exhausted) && !term_prev) term_rise <= cyc;
    if (sub_clear) n_clear <= n_clear + 1;
    if ((key != key_prev) && ((init_cnt | ksa_cnt | prga_cnt) != 3'd0))
      key_moves <= key_moves + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_term(input string tag);
    int n = 0;
    while (!(found || exhausted) && n < 20000) begin @(negedge clk); n++; end
    check(tag, {31'd0, (found || exhausted)}, 32'd1);
    @(negedge clk); #1;
  endtask

  task automatic wait_init_start(input string tag);
    int n = 0;
    while (!init_start && n < 100) begin @(negedge clk); n++; end
    check(tag, {31'd0, init_start}, 32'd1);
  endtask

  task automatic wait_ksa_start(input string tag);
    int n = 0;
    while (!ksa_start && n < 100) begin @(negedge clk); n++; end
    check(tag, {31'd0, ksa_start}, 32'd1);
  endtask

  int clr0;

  initial begin
    // ---- reset state ----
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_found", {31'd0, found}, 32'd0);
    check("rst_exh", {31'd0, exhausted}, 32'd0);
    check("rst_key", {8'd0, key}, 32'd0);
    check("rst_swren", {31'd0, s_wren}, 32'd0);
    check("rst_saddr", {24'd0, s_addr}, 32'd0);
    check("rst_swrdata", {24'd0, s_wrdata}, 32'd0);
    check("rst_decaddr", {24'd0, dec_addr}, 32'd0);
    check("rst_pulses", {28'd0, sub_clear, init_start, ksa_start, prga_start}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // ---- run A: last byte 8'h7B invalid; 7A and 20 accepted ----
    for (int i = 0; i < ML; i++) mem[i] = 8'h61;
    mem[29] = 8'h20; mem[30] = 8'h7A; mem[31] = 8'h7B;
    key_in = 24'h00ABCD;
    good_key = SEARCH ? KMAX : 24'h00ABCD;
    #1 clr0 = n_clear;
    pulse_start();
    wait_init_start("a_init_start");
    inj_wren = 1'b1;
    #1;
    check("own_init_wren_idle", {31'd0, s_wren}, 32'd0);
    check("own_init_addr0", {24'd0, s_addr}, 32'h10);
    check("own_init_data0", {24'd0, s_wrdata}, 32'hA0);
    @(negedge clk); #1;
    check("own_init_addr4", {24'd0, s_addr}, 32'h14);
    check("own_init_data4", {24'd0, s_wrdata}, 32'hA4);
    check("own_init_wren4", {31'd0, s_wren}, 32'd1);
    start = 1'b1; key_in = 24'h555555;
    @(negedge clk);
    start = 1'b0; key_in = 24'h00ABCD; inj_wren = 1'b0;
    wait_term("a_term");
    check("a_exh", {31'd0, exhausted}, 32'd1);
    check("a_found", {31'd0, found}, 32'd0);
    check("a_key", {8'd0, key}, SEARCH ? 32'h3 : 32'h00ABCD);
    check("a_busy", {31'd0, busy}, 32'd0);
    check("a_lat", term_rise - prga_rise, SEARCH ? 32'd130 : 32'd129);
    check("a_decaddr", {24'd0, dec_addr}, 32'd31);
    check("a_clears", n_clear - clr0, SEARCH ? 32'd4 : 32'd1);

    // ---- run B: fully valid message, restart from terminal state ----
    for (int i = 0; i < ML; i++) mem[i] = (i % 3 == 0) ? 8'h61 : ((i % 3 == 1) ? 8'h7A : 8'h20);
    key_in = 24'h001234;
    good_key = SEARCH ? KMAX : 24'h001234;
    clr0 = n_clear;
    pulse_start();
    wait_ksa_start("b_ksa_start");
    #1;
    check("own_ksa_addr0", {24'd0, s_addr}, 32'h20);
    @(negedge clk); #1;
    check("own_ksa_addr4", {24'd0, s_addr}, 32'h24);
    check("own_ksa_wren4", {31'd0, s_wren}, 32'd1);
    wait_term("b_term");
    check("b_found", {31'd0, found}, 32'd1);
    check("b_exh", {31'd0, exhausted}, 32'd0);
    check("b_key", {8'd0, key}, SEARCH ? 32'h3 : 32'h001234);
    check("b_lat", term_rise - prga_rise, 32'd129);
    check("b_clears", n_clear - clr0, SEARCH ? 32'd4 : 32'd1);

    // ---- run C: first byte 8'h60 (just below 'a') fails at once ----
    mem[0] = 8'h60;
    key_in = 24'h000777;
    good_key = SEARCH ? KMAX : 24'h000777;
    pulse_start();
    wait_term("c_term");
    check("c_exh", {31'd0, exhausted}, 32'd1);
    check("c_found", {31'd0, found}, 32'd0);
    check("c_key", {8'd0, key}, SEARCH ? 32'h3 : 32'h000777);
    check("c_lat", term_rise - prga_rise, SEARCH ? 32'd6 : 32'd5);
    check("c_decaddr", {24'd0, dec_addr}, 32'd0);
    check("key_stable", key_moves, 32'd0);

    // ---- run D: reset while KSA is writing ----
    key_in = 24'h00BEEF;
    pulse_start();
    wait_ksa_start("d_ksa_start");
    @(negedge clk); #1;
    check("d_ksa_wren_live", {31'd0, s_wren}, 32'd1);
    reset = 1'b1;
    #1;
    check("d_rst_swren", {31'd0, s_wren}, 32'd0);
    check("d_rst_busy", {31'd0, busy}, 32'd0);
    check("d_rst_key", {8'd0, key}, 32'd0);
    check("d_rst_saddr", {24'd0, s_addr}, 32'd0);
    @(negedge clk); reset = 1'b0;
    clr0 = n_clear;
    repeat (3) @(negedge clk);
    #1;
    check("d_idle_busy", {31'd0, busy}, 32'd0);
    check("d_idle_clears", n_clear - clr0, 32'd0);
    check("d_idle_term", {30'd0, found, exhausted}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
